// File: rtl/debouncer_botoes.sv
// rtl/debouncer_botoes.sv - five-channel push-button debouncer feeding the 2-bit adder
// Outputs stay active-low; changed pulses one cycle after any debounced bit moves.
module debouncer_botoes #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_a,
  input  logic [1:0] btn_b,
  input  logic       btn_cin,
  output logic [1:0] a_db,
  output logic [1:0] b_db,
  output logic       cin_db,
  output logic       changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] stable;
  logic [4:0] stable_d;

  // Bit order: a[1], a[0], b[1], b[0], cin
  assign raw = {btn_a, btn_b, btn_cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < 5; ch++) begin : g_ch
      logic [0:0]    state;
      logic [CW-1:0] cnt;
      logic          stb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= ST_STABLE;
          cnt   <= '0;
          stb   <= 1'b1;
        end else begin
          case (state)
            ST_STABLE: begin
              if (sync2[ch] != stb) begin
                state <= ST_SETTLING;
                cnt   <= CW'(1);
              end
            end
            default: begin
              if (sync2[ch] == stb) begin
                state <= ST_STABLE;
                cnt   <= '0;
              end else if (cnt == CNT_LAST) begin
                stb   <= ~stb;
                state <= ST_STABLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          endcase
        end
      end

      assign stable[ch] = stb;
    end
  endgenerate

  // Comparing against a delayed copy merges simultaneous flips into one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '1;
      changed  <= 1'b0;
    end else begin
      stable_d <= stable;
      changed  <= |(stable ^ stable_d);
    end
  end

  assign a_db   = stable[4:3];
  assign b_db   = stable[2:1];
  assign cin_db = stable[0];

endmodule

// File: doc/debouncer_botoes.md
DEBOUNCER_BOTOES -- requirements
Module: debouncer_botoes

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, meaning stable cycles required before an input change is accepted (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: btn_a  input  2  raw active-low push buttons for operand a, asynchronous to clk.
REQ-005 Port: btn_b  input  2  raw active-low push buttons for operand b, asynchronous to clk.
REQ-006 Port: btn_cin  input  1  raw active-low push button for carry-in, asynchronous to clk.
REQ-007 Port: a_db  output  2  debounced operand a, active-low; drives the 2-bit adder a input directly.
REQ-008 Port: b_db  output  2  debounced operand b, active-low; drives the 2-bit adder b input directly.
REQ-009 Port: cin_db  output  1  debounced carry-in, active-low; drives the adder cin input directly.
REQ-010 Port: changed  output  1  one-cycle pulse, high in the cycle after any debounced output bit changes.

Function
REQ-011 Five independent channels SHALL exist (a[1], a[0], b[1], b[0], cin), all sharing identical logic and DEBOUNCE_CYCLES.
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other use; synchronizer flops reset to 1.
REQ-013 Per channel, a state machine SHALL hold states STABLE and SETTLING plus a stable bit and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-014 STABLE: counter held at 0; if synchronized input differs from stable bit, move to SETTLING with counter = 1.
REQ-015 SETTLING: if synchronized input equals stable bit (bounce back), return to STABLE, counter = 0, stable bit unchanged.
REQ-016 SETTLING: if synchronized input still differs and counter = DEBOUNCE_CYCLES-1, invert stable bit, return to STABLE, counter = 0; otherwise increment counter.
REQ-017 a_db, b_db, cin_db SHALL be the registered stable bits, unmodified in polarity (active-low, 1 = released).
REQ-018 Latency: a clean input edge held steady SHALL appear on the output exactly DEBOUNCE_CYCLES+2 rising edges after first sampling (2 synchronizer + DEBOUNCE_CYCLES settle).
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the output unchanged and SHALL restart qualification from counter = 1 on the next differing sample.
REQ-020 Counter SHALL never wrap; it SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 changed SHALL be high for exactly one cycle when one or more channels update in the same cycle; simultaneous updates produce a single pulse, not several.
REQ-022 Channels updating in consecutive cycles SHALL produce consecutive changed pulses (changed high two cycles).
REQ-023 No combinational path SHALL exist from any btn_* input to any output.

Reset
REQ-024 rst high SHALL immediately (without clk) force: synchronizers = 1, all states STABLE, counters = 0, a_db = 2'b11, b_db = 2'b11, cin_db = 1, changed = 0.
REQ-025 rst asserted mid-SETTLING SHALL discard the pending change; after release, a still-pressed button requires a full DEBOUNCE_CYCLES+2 qualification again.
REQ-026 After rst deassertion, with all buttons released, outputs SHALL remain at reset values and changed SHALL stay 0.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Reset: drive rst=1 with btn_a=2'b00 -> a_db=2'b11, b_db=2'b11, cin_db=1, changed=0 asynchronously; held after release until 6 edges elapse, then a_db=2'b00.
REQ-028 Clean press: btn_b[0] 1->0 held -> b_db[0] falls exactly 6 edges later, changed high exactly the following cycle, all other outputs stay 1.
REQ-029 Bounce: btn_cin toggles 0,1,0,1 every 2 cycles then held 0 -> cin_db stays 1 during bouncing, falls 6 edges after final steady 0, single changed pulse.
REQ-030 Simultaneous: btn_a=2'b00 and btn_b=2'b00 on same edge -> a_db and b_db change on same edge, changed high exactly one cycle; downstream adder sees a=b=3 effective.
REQ-031 Reset mid-settle: press btn_a[1], assert rst after 3 edges for 1 cycle, keep pressed -> a_db[1] stays 1 until 6 edges after rst release.
REQ-032 Release: after REQ-028, btn_b[0] 0->1 held -> b_db[0] rises 6 edges later with one changed pulse; 3-cycle release glitch causes no output change.
